// File: rtl/cr_prefix_pf_pkg.sv
// Shared types and constants for the prefix output FIFO.
package cr_prefix_pf_pkg;

    localparam int unsigned PF_WORD_W           = 9;
    localparam int unsigned N_PREFIX_PF_ENTRIES = 16;
    localparam int unsigned PREFIX_PF_AFULL     = 12;

    typedef struct packed {
        logic       last;
        logic [1:0] rsvd;
        logic [5:0] prefix_idx;
    } pf_word_t;

endpackage

// File: rtl/cr_prefix_pf.sv
// Prefix output FIFO: FWFT storage between the prefix recogniser and its consumer,
// with registered full/afull/valid flags, sticky overflow and a completed-record counter.
module cr_prefix_pf
    import cr_prefix_pf_pkg::*;
#(
    parameter int unsigned DEPTH        = N_PREFIX_PF_ENTRIES,
    parameter int unsigned AFULL_THRESH = PREFIX_PF_AFULL,
    parameter int unsigned FRAME_CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rec_us_prefix_valid,
    input  logic [PF_WORD_W-1:0]       rec_us_pf_datain,
    output logic                       pf_full,
    output logic                       pf_afull,
    output logic [PF_WORD_W-1:0]       pf_dout,
    output logic                       pf_dout_valid,
    input  logic                       pf_dout_rd,
    output logic [$clog2(DEPTH):0]     pf_count,
    input  logic                       regs_pf_flush,
    input  logic                       regs_pf_ovfl_clr,
    output logic                       pf_ovfl_err,
    output logic [FRAME_CNT_W-1:0]     pf_frame_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] LP_AFULL = CW'(AFULL_THRESH);

    pf_word_t                 r_mem [DEPTH];
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_rd_ptr;
    logic [CW-1:0]            r_count;
    logic                     r_full;
    logic                     r_afull;
    logic                     r_valid;
    logic                     r_ovfl;
    logic [FRAME_CNT_W-1:0]   r_frame_cnt;

    logic                     w_wr;
    logic                     w_rd;
    logic                     w_ovfl;
    logic [CW-1:0]            w_count_d;
    pf_word_t                 w_head;

    // Full is registered, so a write while full is rejected even if a pop frees a slot.
    assign w_wr   = rec_us_prefix_valid & ~r_full & ~regs_pf_flush;
    assign w_rd   = pf_dout_rd & r_valid & ~regs_pf_flush;
    assign w_ovfl = rec_us_prefix_valid & r_full;
    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        w_count_d = r_count;
        if (regs_pf_flush) begin
            w_count_d = '0;
        end else begin
            case ({w_wr, w_rd})
                2'b10:   w_count_d = r_count + 1'b1;
                2'b01:   w_count_d = r_count - 1'b1;
                default: w_count_d = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_count <= w_count_d;
            r_full  <= (w_count_d == LP_DEPTH);
            r_afull <= (w_count_d >= LP_AFULL);
            r_valid <= (w_count_d != '0);
            if (regs_pf_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= pf_word_t'(rec_us_pf_datain);
    end

    // Flush clears every flag; otherwise a same-cycle overflow beats the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovfl <= 1'b0;
        end else if (regs_pf_flush) begin
            r_ovfl <= 1'b0;
        end else if (w_ovfl) begin
            r_ovfl <= 1'b1;
        end else if (regs_pf_ovfl_clr) begin
            r_ovfl <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_rd && w_head.last) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign pf_full       = r_full;
    assign pf_afull      = r_afull;
    assign pf_dout_valid = r_valid;
    assign pf_count      = r_count;
    assign pf_ovfl_err   = r_ovfl;
    assign pf_frame_cnt  = r_frame_cnt;
    // Gate the unreset storage so pf_dout reads zero whenever nothing is held.
    assign pf_dout       = r_valid ? w_head : '0;

endmodule

// File: tb/tb_cr_prefix_pf.sv
// Directed self-checking bench for cr_prefix_pf.
module tb_cr_prefix_pf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic [8:0]  wr_data;
    logic        pf_full;
    logic        pf_afull;
    logic [8:0]  pf_dout;
    logic        pf_dout_valid;
    logic        rd;
    logic [4:0]  pf_count;
    logic        flush;
    logic        ovfl_clr;
    logic        pf_ovfl_err;
    logic [15:0] pf_frame_cnt;

    int n_cmp = 0;
    int n_err = 0;

    cr_prefix_pf u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .rec_us_prefix_valid (wr_valid),
        .rec_us_pf_datain    (wr_data),
        .pf_full             (pf_full),
        .pf_afull            (pf_afull),
        .pf_dout             (pf_dout),
        .pf_dout_valid       (pf_dout_valid),
        .pf_dout_rd          (rd),
        .pf_count            (pf_count),
        .regs_pf_flush       (flush),
        .regs_pf_ovfl_clr    (ovfl_clr),
        .pf_ovfl_err         (pf_ovfl_err),
        .pf_frame_cnt        (pf_frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_valid = 1'b0;
        rd       = 1'b0;
        flush    = 1'b0;
        ovfl_clr = 1'b0;
    endtask

    function automatic logic [8:0] stream_word(input int w);
        logic [5:0] idx;
        idx = w[5:0];
        return {(w % 8 == 7), 2'b00, idx};
    endfunction

    initial begin
        idle();
        wr_data = '0;
        rst_n   = 1'b0;
        #12;
        check("rst_count", 32'(pf_count), 0);
        check("rst_flags", {pf_full, pf_afull, pf_dout_valid, pf_ovfl_err}, 0);
        check("rst_dout", 32'(pf_dout), 0);
        check("rst_frame", 32'(pf_frame_cnt), 0);
        rst_n = 1'b1;
        tick();

        // Fill from empty
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = 9'(i);
            tick();
            check("fill_count", 32'(pf_count), 32'(i + 1));
            check("fill_afull", 32'(pf_afull), 32'(i + 1 >= 12));
            check("fill_full", 32'(pf_full), 32'(i == 15));
            check("fill_valid", 32'(pf_dout_valid), 1);
        end
        check("fill_dout", 32'(pf_dout), 0);

        // Overflow while full
        wr_data = 9'h1AA;
        tick();
        wr_valid = 1'b0;
        check("ovfl_err", 32'(pf_ovfl_err), 1);
        check("ovfl_count", 32'(pf_count), 16);
        rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_dout", 32'(pf_dout), 32'(i));
            tick();
        end
        rd = 1'b0;
        check("drain_empty", {pf_count, pf_dout_valid}, 0);
        check("drain_frame", 32'(pf_frame_cnt), 0);
        check("ovfl_sticky", 32'(pf_ovfl_err), 1);
        ovfl_clr = 1'b1;
        tick();
        ovfl_clr = 1'b0;
        check("ovfl_clr", 32'(pf_ovfl_err), 0);

        // Full with simultaneous write and pop
        wr_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 9'(i);
            tick();
        end
        check("refill_full", 32'(pf_full), 1);
        wr_data = 9'h055;
        rd      = 1'b1;
        tick();
        idle();
        check("wp_ovfl", 32'(pf_ovfl_err), 1);
        check("wp_count", 32'(pf_count), 15);
        check("wp_full", 32'(pf_full), 0);
        ovfl_clr = 1'b1;
        rd       = 1'b1;
        for (int i = 1; i < 16; i++) begin
            check("wp_drain", 32'(pf_dout), 32'(i));
            tick();
            ovfl_clr = 1'b0;
        end
        rd = 1'b0;
        check("wp_empty", 32'(pf_count), 0);

        // Streaming across pointer wrap
        wr_valid = 1'b1;
        wr_data  = stream_word(0);
        tick();
        rd = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            wr_data = stream_word(k);
            check("stream_dout", 32'(pf_dout), 32'(stream_word(k - 1)));
            tick();
            check("stream_count", 32'(pf_count), 1);
        end
        check("stream_frame", 32'(pf_frame_cnt), 8);
        wr_valid = 1'b0;
        check("stream_last", 32'(pf_dout), 32'(stream_word(64)));
        tick();
        rd = 1'b0;
        check("stream_empty", 32'(pf_dout_valid), 0);

        // Flush with concurrent write and pop
        wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 9'h100 | 9'(i);
            tick();
        end
        check("pre_flush", 32'(pf_count), 5);
        flush = 1'b1;
        rd    = 1'b1;
        tick();
        idle();
        check("flush_count", 32'(pf_count), 0);
        check("flush_valid", 32'(pf_dout_valid), 0);
        check("flush_frame", 32'(pf_frame_cnt), 8);
        check("flush_flags", {pf_full, pf_afull}, 0);

        // Asynchronous reset mid-operation
        wr_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wr_data = 9'(i + 3);
            tick();
        end
        wr_valid = 1'b0;
        check("pre_rst", 32'(pf_count), 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(pf_count), 0);
        check("arst_flags", {pf_full, pf_afull, pf_dout_valid, pf_ovfl_err}, 0);
        check("arst_dout", 32'(pf_dout), 0);
        check("arst_frame", 32'(pf_frame_cnt), 0);
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        wr_valid = 1'b1;
        wr_data  = 9'h03F;
        tick();
        wr_valid = 1'b0;
        check("post_rst_valid", 32'(pf_dout_valid), 1);
        check("post_rst_dout", 32'(pf_dout), 32'h03F);
        check("post_rst_count", 32'(pf_count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cr_prefix_pf.md
Name: cr_prefix_pf

Overview:
- Prefix output FIFO directly downstream of the prefix recogniser.
- Accepts 9-bit prefix words on the recogniser's valid strobe and returns full/almost-full backpressure to its microsequencer.
- Presents words first-word-fall-through (FWFT) to the downstream prefix consumer with a valid/read handshake.
- Keeps occupancy, a sticky overflow flag and a completed-record counter for the register block.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >=4.
- AFULL_THRESH, 12, pf_afull asserts when occupancy >= this value; must be < DEPTH.
- FRAME_CNT_W, 16, width of pf_frame_cnt.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- rec_us_prefix_valid  in  1  write strobe from recogniser
- rec_us_pf_datain  in  9  bit8 = last-of-record, [7:6] reserved (stored as given), [5:0] prefix index
- pf_full  out  1  occupancy == DEPTH
- pf_afull  out  1  occupancy >= AFULL_THRESH
- pf_dout  out  9  head entry
- pf_dout_valid  out  1  FIFO not empty
- pf_dout_rd  in  1  consumer pop; honoured only when pf_dout_valid
- pf_count  out  log2(DEPTH)+1  current occupancy
- regs_pf_flush  in  1  synchronous flush pulse
- regs_pf_ovfl_clr  in  1  clears sticky overflow
- pf_ovfl_err  out  1  sticky: write attempted while full
- pf_frame_cnt  out  FRAME_CNT_W  count of popped words with bit8 = 1

Behaviour:
- Clock and reset:
  - Single clock domain (clk).
  - rst_n is asynchronous, active-low.
  - Reset values: pointers and count = 0, pf_full = 0, pf_afull = 0, pf_dout_valid = 0, pf_dout = 0, pf_ovfl_err = 0, pf_frame_cnt = 0.
  - Storage array is not reset.
- Storage and pointers:
  - Register array of DEPTH x 9.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Occupancy counter is log2(DEPTH)+1 bits.
- Flags:
  - pf_full, pf_afull and pf_dout_valid are registered, derived from next-state occupancy. They are exact in the same cycle the count changes.
- Write:
  - Accepted when rec_us_prefix_valid & ~pf_full.
  - Data is stored at wr_ptr and wr_ptr increments.
- Overflow:
  - rec_us_prefix_valid & pf_full drops the word and sets pf_ovfl_err.
  - Pointers and count are unchanged.
- Read:
  - pf_dout = mem[rd_ptr] combinationally (FWFT).
  - Pop occurs when pf_dout_rd & pf_dout_valid; rd_ptr increments.
  - pf_dout_rd while empty is ignored with no error.
- Latency: a word written in cycle N is visible on pf_dout with pf_dout_valid = 1 in cycle N+1.
- Simultaneous write and pop:
  - Count unchanged; both pointers advance.
  - When full, the write is rejected because full is registered, even if a pop occurs the same cycle. The pop still happens and the next cycle is not full.
  - When empty, there is no pop (valid = 0); the write proceeds.
- pf_frame_cnt:
  - Increments on each pop whose pf_dout[8] = 1.
  - Wraps from all-ones to 0.
  - Not cleared by flush.
- regs_pf_flush:
  - Next cycle: pointers = 0, count = 0, all flags deasserted.
  - Any write or pop in the flush cycle is discarded.
  - Flush has priority over everything except rst_n.
- regs_pf_ovfl_clr:
  - Clears pf_ovfl_err.
  - If an overflow occurs in the same cycle, set wins.
- Reset mid-operation: all contents are lost immediately; no residual valid.

Decomposition:
- cr_prefixPKG additions:
  - pf_word_t packed struct {last, rsvd[1:0], prefix_idx[5:0]}
  - constants N_PREFIX_PF_ENTRIES = 16 and PREFIX_PF_AFULL = 12
- No sub-module. Pointer/count logic, storage and the frame counter are each small enough to stay inline in one module.

Test Plan:
- Fill from empty: 16 consecutive writes 0x000..0x00F, no reads.
  - pf_afull rises the cycle after the 12th write.
  - pf_full rises after the 16th; pf_count = 16.
  - pf_dout = 0x000.
- Overflow: with FIFO full, write 0x1AA.
  - pf_ovfl_err = 1; pf_count stays 16.
  - Drain order is 0x000..0x00F with 0x1AA absent.
  - regs_pf_ovfl_clr then clears pf_ovfl_err.
- Full plus simultaneous write/pop: FIFO full, assert write 0x055 and pf_dout_rd together.
  - Write rejected; pf_ovfl_err = 1; pf_count = 15; pf_full = 0 next cycle.
- Streaming: write and pop every cycle for 64 cycles, with every 8th word having bit8 = 1.
  - pf_count holds at 1; data order is preserved across pointer wrap.
  - pf_frame_cnt = 8.
- Flush: with 5 entries, pulse regs_pf_flush together with a write and a pop.
  - Next cycle: pf_count = 0, pf_dout_valid = 0, pf_frame_cnt unchanged.
- Reset mid-operation: with 7 entries, drive rst_n low asynchronously, between clock edges.
  - All outputs go to reset values immediately.
  - After release, the first write 0x03F appears next cycle with pf_dout_valid = 1.
